// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with 2-entry response FIFO and redirect
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   imem_re_o      instruction-memory read request
//   imem_addr_o    word address of the request (current pc)
//   imem_data_i    read data, valid exactly one cycle after a request
//   br_taken_i     redirect strobe from EX; overrides stall and issue
//   br_addr_i      redirect target
//   stall_i        decode backpressure; head is held while high
//   v_o            inst_o/origaddr_o carry a valid instruction
//   inst_o         fetched instruction (FIFO head)
//   origaddr_o     address of inst_o
module ifetch #(
  parameter int                ADDR_W     = 16,
  parameter int                WORD_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_re_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [WORD_W-1:0] imem_data_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              stall_i,
  output logic              v_o,
  output logic [WORD_W-1:0] inst_o,
  output logic [ADDR_W-1:0] origaddr_o
);

  logic [ADDR_W-1:0] pc_r;
  logic              infl_r;
  logic [ADDR_W-1:0] infl_addr_r;
  logic [1:0]        count_r;

  // Entry 0 is always the head; entry 1 only holds data when count_r == 2.
  logic [WORD_W-1:0] inst_q0, inst_q1;
  logic [ADDR_W-1:0] addr_q0, addr_q1;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ_after;

  assign v_o  = ~rst & (count_r != 2'd0) & ~br_taken_i;
  assign pop  = v_o & ~stall_i;
  assign push = infl_r & ~br_taken_i;

  // Occupancy once this cycle's pop is applied, counting the response still
  // on its way; a new request is only allowed if it is guaranteed a slot.
  assign occ_after = {1'b0, count_r} + {2'b0, infl_r} - {2'b0, pop};
  assign issue     = ~rst & ~br_taken_i & (occ_after < 3'd2);

  assign imem_re_o   = issue;
  assign imem_addr_o = pc_r;
  assign inst_o      = rst ? '0 : inst_q0;
  assign origaddr_o  = rst ? '0 : addr_q0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_ADDR;
      infl_r      <= 1'b0;
      infl_addr_r <= '0;
      count_r     <= 2'd0;
      inst_q0     <= '0;
      inst_q1     <= '0;
      addr_q0     <= '0;
      addr_q1     <= '0;
    end else if (br_taken_i) begin
      // Flush: buffered entries, the in-flight response and any data
      // arriving this cycle are all discarded.
      count_r <= 2'd0;
      infl_r  <= 1'b0;
      pc_r    <= br_addr_i;
    end else begin
      infl_r <= issue;
      if (issue) begin
        infl_addr_r <= pc_r;
        pc_r        <= pc_r + ADDR_W'(1);
      end

      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            inst_q0 <= imem_data_i;
            addr_q0 <= infl_addr_r;
          end else begin
            inst_q1 <= imem_data_i;
            addr_q1 <= infl_addr_r;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          inst_q0 <= inst_q1;
          addr_q0 <= addr_q1;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (count_r == 2'd1) begin
            inst_q0 <= imem_data_i;
            addr_q0 <= infl_addr_r;
          end else begin
            inst_q0 <= inst_q1;
            addr_q0 <= addr_q1;
            inst_q1 <= imem_data_i;
            addr_q1 <= infl_addr_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch against a queue-based model
module tb_ifetch;

  localparam logic [15:0] RST_A = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_re_o;
  logic [15:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        br_taken_i;
  logic [15:0] br_addr_i;
  logic        stall_i;
  logic        v_o;
  logic [31:0] inst_o;
  logic [15:0] origaddr_o;

  ifetch #(.ADDR_W(16), .WORD_W(32), .RESET_ADDR(RST_A)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_re_o   (imem_re_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_i (imem_data_i),
    .br_taken_i  (br_taken_i),
    .br_addr_i   (br_addr_i),
    .stall_i     (stall_i),
    .v_o         (v_o),
    .inst_o      (inst_o),
    .origaddr_o  (origaddr_o)
  );

  always #5 clk = ~clk;

  // Memory: mem[a] = a + 0x100, one-cycle read latency; garbage when idle.
  always @(posedge clk) begin
    if (imem_re_o) imem_data_i <= 32'(imem_addr_o) + 32'h100;
    else           imem_data_i <= $urandom();
  end

  int compared   = 0;
  int mismatched = 0;

  // Model: addresses ready for decode, one pending response, next fetch address.
  logic [15:0] avail[$];
  logic        pend;
  logic [15:0] pend_addr;
  logic [15:0] next_req;

  logic [15:0] log_q[$];
  int          re_cnt;
  logic        last_v, last_re;
  logic [15:0] last_orig, last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic b, input logic [15:0] ba, input logic s);
    logic exp_v, exp_pop, exp_re;
    int   occ;
    rst = r; br_taken_i = b; br_addr_i = ba; stall_i = s;
    @(negedge clk);
    exp_v   = !r && !b && (avail.size() > 0);
    exp_pop = exp_v && !s;
    occ     = avail.size() + (pend ? 1 : 0) - (exp_pop ? 1 : 0);
    exp_re  = !r && !b && (occ < 2);
    chk("v_o", 32'(v_o), 32'(exp_v));
    chk("imem_re_o", 32'(imem_re_o), 32'(exp_re));
    if (exp_re) chk("imem_addr_o", 32'(imem_addr_o), 32'(next_req));
    if (exp_v) begin
      chk("origaddr_o", 32'(origaddr_o), 32'(avail[0]));
      chk("inst_o", inst_o, 32'(avail[0]) + 32'h100);
    end
    if (r) begin
      chk("rst_inst_o", inst_o, 32'h0);
      chk("rst_origaddr_o", 32'(origaddr_o), 32'h0);
    end
    last_v = v_o; last_re = imem_re_o; last_orig = origaddr_o; last_addr = imem_addr_o;
    if (v_o && !s) log_q.push_back(origaddr_o);
    if (imem_re_o) re_cnt++;
    if (r) begin
      avail.delete(); pend = 1'b0; next_req = RST_A;
    end else if (b) begin
      avail.delete(); pend = 1'b0; next_req = ba;
    end else begin
      if (exp_pop) void'(avail.pop_front());
      if (pend) avail.push_back(pend_addr);
      pend      = exp_re;
      pend_addr = next_req;
      if (exp_re) next_req = next_req + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string tag, input logic [15:0] start, input int n);
    logic [15:0] a;
    chk({tag, "_len"}, 32'(log_q.size() >= n), 32'h1);
    a = start;
    for (int i = 0; i < n; i++) begin
      if (i < log_q.size()) chk(tag, 32'(log_q[i]), 32'(a));
      a = a + 16'd1;
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; br_taken_i = 1'b0; br_addr_i = '0; stall_i = 1'b0;
    avail.delete(); pend = 1'b0; pend_addr = '0; next_req = RST_A;
    @(posedge clk);
    #1;

    // Reset
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);

    // Stream from reset until head reaches 4
    log_q.delete();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (avail.size() > 0 && avail[0] == 16'h4) found = 1;
      else tick(0, 0, 0, 0);
    end
    chk("head4_reached", 32'(found), 32'h1);
    chk_seq("stream_from_reset", RST_A, 4);

    // Stall 5 cycles at head 4
    re_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1);
      chk("stall_v", 32'(last_v), 32'h1);
      chk("stall_head", 32'(last_orig), 32'h4);
    end
    chk("stall_req_le2", 32'(re_cnt <= 2), 32'h1);
    log_q.delete();
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0);
    chk_seq("after_stall", 16'h4, 6);

    // Fill FIFO, then redirect to 0x40
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (avail.size() == 2) found = 1;
      else tick(0, 0, 0, 1);
    end
    chk("fifo_full", 32'(found), 32'h1);
    tick(0, 1, 16'h0040, 0);
    chk("br_v_low", 32'(last_v), 32'h0);
    log_q.delete();
    tick(0, 0, 0, 0);
    chk("br_next_addr", 32'(last_addr), 32'h40);
    chk("br_next_re", 32'(last_re), 32'h1);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    chk_seq("after_br40", 16'h0040, 4);

    // Redirect together with stall
    tick(0, 1, 16'h0200, 1);
    log_q.delete();
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    chk_seq("br_with_stall", 16'h0200, 3);

    // Back-to-back redirects: last wins
    tick(0, 1, 16'h0080, 0);
    tick(0, 1, 16'h0090, 0);
    log_q.delete();
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    chk_seq("double_br", 16'h0090, 3);

    // Address wrap
    tick(0, 1, 16'hFFFF, 0);
    log_q.delete();
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    chk_seq("wrap", 16'hFFFF, 3);

    // Reset mid-stream
    tick(1, 0, 0, 0);
    chk("midrst_v", 32'(last_v), 32'h0);
    chk("midrst_re", 32'(last_re), 32'h0);
    log_q.delete();
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    chk_seq("after_midrst", RST_A, 3);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      tick($urandom_range(99) < 1, $urandom_range(99) < 5,
           16'($urandom()), $urandom_range(99) < 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
